contador_bcd_multitempo: RTL
============================

// Module: contador_bcd_multitempo
// PURPOSE
//  Multi-digit BCD up/down counter with four selectable count periods, pause,
//  parallel load and per-digit 7-segment outputs. Replaces the divided-clock
//  scheme: everything runs on clock50. The period selector drives a one-cycle
//  tick enable, not a derived clock. Sits between board switches and HEX displays.
// PARAMETERS
//  CLK_HZ    50_000_000  clock50 frequency in Hz. Must be a multiple of 1000.
//  N_DIGITS  2           BCD digits counted and displayed (1..8).
//  MODULO    100         count range 0..MODULO-1 (2..10**N_DIGITS).
//  P0_MS     500         period in ms for sel=0; likewise P1_MS=1000, P2_MS=2000, P3_MS=6000.
// PORTS
//  clock50   in   1            sole clock, rising edge
//  rst       in   1            synchronous reset, active-high
//  sel       in   2            period select: 0=P0_MS 1=P1_MS 2=P2_MS 3=P3_MS
//  en        in   1            1=count, 0=pause (prescaler and count hold)
//  up_down   in   1            1=count up, 0=count down
//  load      in   1            1-cycle parallel load strobe
//  load_val  in   4*N_DIGITS   BCD load value, digit0 in [3:0]
//  bcd       out  4*N_DIGITS   current count in BCD, digit0 in [3:0]
//  hex       out  7*N_DIGITS   active-low segments; digit k in [7k+6:7k]; bit0=a .. bit6=g
//  tick      out  1            1-cycle pulse on every count step
//  wrap      out  1            1-cycle pulse on a step that wraps the count
// BEHAVIOUR
//  Period in cycles: PER(sel) = CLK_HZ/1000*Px_MS. Prescaler width = clog2(max PER).
//  Registered state: prescaler, count (BCD digits), sel_q, tick, wrap.
//  Reset (rst=1 at an edge): prescaler=0, count=0, sel_q=sel, tick=0, wrap=0.
//   hex shows "0" on every digit (7'b1000000 each). rst overrides all inputs.
//  Priority per edge: rst > load > sel change > en/tick > hold.
//  load=1: count=load_val and prescaler=0. tick=0, wrap=0 that cycle.
//   load_val is invalid if any digit is >9 or the value is >=MODULO.
//   An invalid load_val loads 0.
//  Sel change (sel!=sel_q): sel_q=sel and prescaler=0; no tick that cycle.
//   The first tick after a change comes exactly PER(new sel) cycles later.
//  en=0: prescaler and count hold; tick=0, wrap=0.
//  en=1, prescaler<PER-1: prescaler+1, tick=0.
//  en=1, prescaler==PER-1: prescaler=0; tick=1 on the next cycle.
//   The count updates on the same edge, so bcd/hex change in the cycle tick is high.
//  Step up: MODULO-1 -> 0 with wrap=1; otherwise +1 with decimal carry between digits.
//  Step down: 0 -> MODULO-1 with wrap=1; otherwise -1 with decimal borrow.
//  up_down is sampled at the step edge. A direction change needs no resync.
//  tick and wrap are 1 for exactly one cycle per step; wrap only coincides with tick.
//  Steady en=1 and fixed sel: exactly one step every PER(sel) cycles.
//  hex is combinational from the count register, so it has zero latency vs bcd.
//   Digit encodings (gfedcba, active-low):
//   0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//  Pausing mid-period keeps the prescaler, so the period resumes where it stopped.
//  rst or load mid-period discards the partial period.
// TESTING  (bench: CLK_HZ=1000, so 1 cycle = 1 ms)
//  rst 3 cycles, sel=0, en=1, up=1 -> bcd=00, hex=2x7'b1000000; first tick 500 cycles after rst release, bcd=01.
//  MODULO=100, load 98 (0x98), up -> ticks give 99, then 00 with wrap=1 in the same cycle; digit carry 09->10 correct.
//  load 01, up_down=0 -> 00, then 99 with wrap=1; load 0xA5 -> bcd=00.
//  sel=3 steady -> 6000 cycles between ticks; sel 3->1 at cycle 2500 of a period -> next tick exactly 1000 cycles after the change.
//  en=0 for 300 cycles after 200 cycles of sel=0 -> next tick 300 cycles after en returns to 1; count unchanged during the pause.
//  rst asserted while load=1 and tick is due -> count=0, tick=0, wrap=0.

Source files
------------

// File: rtl/contador_bcd_multitempo.sv
// Multi-digit BCD up/down counter stepped by a one-cycle tick enable derived from
// a selectable period prescaler, with pause, parallel load and 7-segment outputs.
module contador_bcd_multitempo #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int N_DIGITS = 2,
  parameter int MODULO   = 100,
  parameter int P0_MS    = 500,
  parameter int P1_MS    = 1000,
  parameter int P2_MS    = 2000,
  parameter int P3_MS    = 6000
) (
  input  logic                  clock50,
  input  logic                  rst,
  input  logic [1:0]            sel,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic [7*N_DIGITS-1:0] hex,
  output logic                  tick,
  output logic                  wrap
);

  localparam int PER0    = CLK_HZ / 1000 * P0_MS;
  localparam int PER1    = CLK_HZ / 1000 * P1_MS;
  localparam int PER2    = CLK_HZ / 1000 * P2_MS;
  localparam int PER3    = CLK_HZ / 1000 * P3_MS;
  localparam int PER01   = (PER0 > PER1) ? PER0 : PER1;
  localparam int PER23   = (PER2 > PER3) ? PER2 : PER3;
  localparam int PER_MAX = (PER01 > PER23) ? PER01 : PER23;
  localparam int PW      = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;

  localparam logic [PW-1:0] LAST0 = PW'(PER0 - 1);
  localparam logic [PW-1:0] LAST1 = PW'(PER1 - 1);
  localparam logic [PW-1:0] LAST2 = PW'(PER2 - 1);
  localparam logic [PW-1:0] LAST3 = PW'(PER3 - 1);

  function automatic logic [4*N_DIGITS-1:0] to_bcd(input int v);
    logic [4*N_DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // With valid digits a BCD word orders the same way as its binary reading.
  localparam logic [4*N_DIGITS-1:0] COUNT_MAX = to_bcd(MODULO - 1);

  logic [PW-1:0]           presc_reg, presc_next;
  logic [4*N_DIGITS-1:0]   count_reg, count_next;
  logic [1:0]              sel_q_reg, sel_q_next;
  logic                    tick_reg, tick_next;
  logic                    wrap_reg, wrap_next;

  logic [4*N_DIGITS-1:0]   count_inc, count_dec;
  logic [N_DIGITS-1:0]     digit_ok;
  logic [PW-1:0]           per_last;
  logic                    load_ok, at_max, at_zero;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign digit_ok[gi]      = (load_val[4*gi +: 4] <= 4'd9);
      assign hex[7*gi +: 7]    = seg7(count_reg[4*gi +: 4]);
    end
  endgenerate

  // Ripple decimal carry/borrow across digits.
  always_comb begin
    logic       up_c, dn_b;
    logic [3:0] d;
    count_inc = '0;
    count_dec = '0;
    up_c      = 1'b1;
    dn_b      = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      d = count_reg[4*i +: 4];
      count_inc[4*i +: 4] = up_c ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
      count_dec[4*i +: 4] = dn_b ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
      up_c = up_c && (d == 4'd9);
      dn_b = dn_b && (d == 4'd0);
    end
  end

  always_comb begin
    case (sel_q_reg)
      2'd0:    per_last = LAST0;
      2'd1:    per_last = LAST1;
      2'd2:    per_last = LAST2;
      default: per_last = LAST3;
    endcase
  end

  assign load_ok = (&digit_ok) && (load_val <= COUNT_MAX);
  assign at_max  = (count_reg == COUNT_MAX);
  assign at_zero = (count_reg == '0);

  always_comb begin
    presc_next = presc_reg;
    count_next = count_reg;
    sel_q_next = sel_q_reg;
    tick_next  = 1'b0;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_ok ? load_val : '0;
      presc_next = '0;
      sel_q_next = sel;
    end else if (sel != sel_q_reg) begin
      sel_q_next = sel;
      presc_next = '0;
    end else if (en) begin
      if (presc_reg == per_last) begin
        presc_next = '0;
        tick_next  = 1'b1;
        if (up_down) begin
          count_next = at_max ? '0 : count_inc;
          wrap_next  = at_max;
        end else begin
          count_next = at_zero ? COUNT_MAX : count_dec;
          wrap_next  = at_zero;
        end
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clock50) begin
    if (rst) begin
      presc_reg <= '0;
      count_reg <= '0;
      sel_q_reg <= sel;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      count_reg <= count_next;
      sel_q_reg <= sel_q_next;
      tick_reg  <= tick_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign bcd  = count_reg;
  assign tick = tick_reg;
  assign wrap = wrap_reg;

endmodule
